// File: rtl/riscv_pkg.sv
// Types and constants shared by the fetch stage: FSM encoding, queue entry
// layout, NOP encoding and PC step.
package riscv_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, execute redirect and
// the decode-side instruction handshake.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] Instr;
  logic [31:0] instr_pc;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, Instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rdata, redirect, redirect_pc,
           instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, Instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rdata, redirect, redirect_pc,
           instr_ready
  );
endinterface

// File: rtl/instr_queue.sv
// Small FIFO of fetched {pc, instr} pairs with flush; head is combinational
// from the slot addressed by the read pointer.
module instr_queue
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;
  fetch_entry_t     slots [DEPTH];

  assign do_pop  = pop && (count_reg != '0);
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign do_push = push && ((count_reg < CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      fetch_entry_t data_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= '0;
        end else if (do_push && !flush && (wr_ptr_reg == PTR_W'(gi))) begin
          data_reg <= push_entry;
        end
      end

      assign slots[gi] = data_reg;
    end
  endgenerate

  assign count = count_reg;
  assign head  = slots[rd_ptr_reg];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register and request FSM (at most one outstanding
// memory request) feeding a 2-entry instruction queue towards decode.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(QDEPTH + 1);

  fetch_state_t     state_reg, state_next;
  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic             req_valid;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] queue_count;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FETCH;
      fetch_pc_reg <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    req_valid     = 1'b0;
    push          = 1'b0;
    case (state_reg)
      FETCH: begin
        // No request while reset is held; nothing is outstanding in FETCH.
        req_valid = rst_n && !bus.redirect && (queue_count < CNT_W'(QDEPTH));
        if (bus.redirect) begin
          fetch_pc_next = word_align(bus.redirect_pc);
        end else if (req_valid && bus.imem_req_ready) begin
          state_next    = WAIT;
          fetch_pc_next = fetch_pc_reg + PC_STEP;
        end
      end
      WAIT: begin
        if (bus.redirect) begin
          fetch_pc_next = word_align(bus.redirect_pc);
          state_next    = bus.imem_rsp_valid ? FETCH : DRAIN;
        end else if (bus.imem_rsp_valid) begin
          push       = 1'b1;
          state_next = FETCH;
        end
      end
      DRAIN: begin
        if (bus.redirect) fetch_pc_next = word_align(bus.redirect_pc);
        // The stale response always ends the drain, even alongside a new redirect.
        if (bus.imem_rsp_valid) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // fetch_pc advanced by one step when the outstanding request was accepted.
  assign push_entry = '{pc: fetch_pc_reg - PC_STEP, instr: bus.imem_rdata};
  assign pop        = bus.instr_valid && bus.instr_ready && !bus.redirect;

  instr_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .flush     (bus.redirect),
    .count     (queue_count),
    .head      (head)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = fetch_pc_reg;
  assign bus.instr_valid    = (queue_count != '0);
  assign bus.Instr          = bus.instr_valid ? head.instr : NOP_INSTR;
  assign bus.instr_pc       = bus.instr_valid ? head.pc : 32'h0000_0000;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter QDEPTH, default 2, giving the instruction queue depth; only the value 2 is supported.
REQ-003 The block SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  in  1  the reset; asynchronous, active-low.
REQ-005 The block SHALL have port imem_req_valid  out  1  the fetch request is valid.
REQ-006 The block SHALL have port imem_req_ready  in  1  instruction memory accepts the request.
REQ-007 The block SHALL have port imem_addr  out  32  the fetch address, always word-aligned.
REQ-008 The block SHALL have port imem_rsp_valid  in  1  instruction memory returns data.
REQ-009 The block SHALL have port imem_rdata  in  32  the returned instruction word.
REQ-010 The block SHALL have port redirect  in  1  a taken branch or jump from execute.
REQ-011 The block SHALL have port redirect_pc  in  32  the branch or jump target (PC + ImmExt).
REQ-012 The block SHALL have port instr_valid  out  1  the queue head holds a valid instruction.
REQ-013 The block SHALL have port instr_ready  in  1  decode consumes the head.
REQ-014 The block SHALL have port Instr  out  32  the head instruction, feeding decode and the immediate extend unit.
REQ-015 The block SHALL have port instr_pc  out  32  the address of the head instruction.

Function
REQ-016 The FSM SHALL have three states: FETCH (may issue a request), WAIT (one request outstanding) and DRAIN (the outstanding response is to be discarded).
REQ-017 A request SHALL be accepted when imem_req_valid && imem_req_ready.
REQ-018 At most one request SHALL be outstanding at any time.
REQ-019 In FETCH, imem_req_valid SHALL be 1 only when queue count + outstanding < 2.
REQ-020 In FETCH, imem_addr SHALL equal fetch_pc.
REQ-021 On request accept, the FSM SHALL move FETCH->WAIT and fetch_pc SHALL become fetch_pc + 4; the address is wrapped modulo 2^32.
REQ-022 In WAIT, when imem_rsp_valid is 1, the block SHALL push {pc, imem_rdata} into the queue and the FSM SHALL move WAIT->FETCH.
REQ-023 The pushed entry SHALL become visible on instr_valid/Instr/instr_pc in the next cycle.
REQ-024 In WAIT, a back-to-back request SHALL NOT be issued in the same cycle as the response.
REQ-025 instr_valid SHALL be 1 when count != 0; Instr and instr_pc SHALL come from the head entry.
REQ-026 A pop SHALL occur when instr_valid && instr_ready.
REQ-027 A push and a pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-028 When count == 0, Instr SHALL read 32'h0000_0013 (NOP) and instr_pc SHALL read 0.
REQ-029 On redirect, the block SHALL flush the queue (count = 0), ignore any pop that cycle, and set fetch_pc = {redirect_pc[31:2], 2'b00}.
REQ-030 On redirect in WAIT without imem_rsp_valid in the same cycle, the FSM SHALL move to DRAIN.
REQ-031 A redirect in the same cycle as imem_rsp_valid SHALL discard the response and the FSM SHALL move to FETCH.
REQ-032 On redirect in FETCH, no request SHALL be issued that cycle; the FSM SHALL stay in FETCH.
REQ-033 In DRAIN, imem_req_valid SHALL be 0; imem_rsp_valid SHALL be discarded and the FSM SHALL move to FETCH.
REQ-034 A second redirect while in DRAIN SHALL update fetch_pc and the FSM SHALL stay in DRAIN.
REQ-035 With a memory that has ready=1 and returns the response one cycle after the request, the latency from request to instr_valid SHALL be 2 cycles.
REQ-036 With that memory and instr_ready held at 1, sustained throughput SHALL be one instruction every 2 cycles.

Reset
REQ-037 While rst_n = 0, the block SHALL force state = FETCH, fetch_pc = RESET_PC, count = 0 and outstanding = 0, so imem_req_valid = 0 and instr_valid = 0.
REQ-038 In the first cycle after rst_n rises, imem_req_valid SHALL be 1 with imem_addr = RESET_PC.
REQ-039 A reset asserted mid-transaction SHALL abandon the outstanding request, and any response arriving after reset release SHALL be ignored unless the FSM is in WAIT.

Structure
REQ-040 Shared package riscv_pkg SHALL hold the fetch_state_t enum (FETCH, WAIT, DRAIN), the constant NOP_INSTR = 32'h0000_0013 and the constant PC_STEP = 4.
REQ-041 Sub-module instr_queue SHALL be a 2-entry FIFO of {pc[31:0], instr[31:0]} with push, pop, flush, count, head outputs and the same clk/rst_n.
REQ-042 The FSM and the PC register SHALL live in fetch_unit.

Verification
REQ-043 The bench SHALL cover: reset release with RESET_PC=0, memory ready=1, 1-cycle latency, instr_ready=1 -> instr_pc sequence 0,4,8 with instr_valid at cycles 2,4,6.
REQ-044 The bench SHALL cover: instr_ready=0 for 10 cycles -> count saturates at 2, imem_req_valid=0, then the queue drains in order 0,4.
REQ-045 The bench SHALL cover: redirect to 32'h0000_0100 while in WAIT -> the old response is dropped, next imem_addr = 0x100 and the next instr_pc = 0x100.
REQ-046 The bench SHALL cover: redirect_pc = 32'h0000_0102 -> imem_addr = 0x100.
REQ-047 The bench SHALL cover: redirect coincident with imem_rsp_valid -> the response is not queued, and a request to the target is issued the next cycle.
REQ-048 The bench SHALL cover: fetch_pc = 32'hFFFF_FFFC -> the next address is 32'h0000_0000; and rst_n low mid-WAIT -> outputs zero, refetch from RESET_PC.
